// File: rtl/hazard_info_pipe.sv
// rtl/hazard_info_pipe.sv - per-stage hazard bookkeeping pipeline (E/M/W) with stall bubble and stall counter
//
// Purpose: carries each instruction's destination register, source registers
// and Tnew from decode through E, M and W. The E/M/W records feed the
// hazard-resolution unit, and the `stall` input it produces bubbles E.
//
// Ports:
//   clk         rising-edge clock
//   reset       asynchronous active-low reset, clears every record and the counter
//   stall       freeze D / insert bubble into E on this edge
//   Tnew_D      result latency of the decoding instruction (0 none, 1 ALU, 2 load)
//   regA3_D     destination register in D (0 = no write)
//   regA1_D/A2  source registers in D
//   Tnew_E/M/W  remaining latency per stage
//   regA3_E/M/W destination register per stage
//   regA1_E/A2_E sources of the instruction in E
//   regA2_M     rt of the instruction in M
//   stallCount  saturating count of stall cycles

module hazard_info_pipe #(
  parameter int REG_W  = 5,
  parameter int TNEW_W = 3,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic [TNEW_W-1:0] Tnew_D,
  input  logic [REG_W-1:0]  regA3_D,
  input  logic [REG_W-1:0]  regA1_D,
  input  logic [REG_W-1:0]  regA2_D,
  output logic [TNEW_W-1:0] Tnew_E,
  output logic [TNEW_W-1:0] Tnew_M,
  output logic [TNEW_W-1:0] Tnew_W,
  output logic [REG_W-1:0]  regA3_E,
  output logic [REG_W-1:0]  regA3_M,
  output logic [REG_W-1:0]  regA3_W,
  output logic [REG_W-1:0]  regA1_E,
  output logic [REG_W-1:0]  regA2_E,
  output logic [REG_W-1:0]  regA2_M,
  output logic [CNT_W-1:0]  stallCount
);

  localparam logic [TNEW_W-1:0] TNEW_MAX = TNEW_W'(2);

  logic [TNEW_W-1:0] tnewCapture;

  // A write to r0 never produces a result anyone waits on, so it carries no
  // latency; otherwise latencies beyond a load's are clamped to a load's.
  always_comb begin
    tnewCapture = '0;
    if (regA3_D != '0) begin
      tnewCapture = (Tnew_D > TNEW_MAX) ? TNEW_MAX : Tnew_D;
    end
  end

  function automatic logic [TNEW_W-1:0] satDec(input logic [TNEW_W-1:0] x);
    return (x != '0) ? x - TNEW_W'(1) : '0;
  endfunction

  // E stage: new instruction, or an all-zero bubble while D is frozen.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      Tnew_E  <= '0;
      regA3_E <= '0;
      regA1_E <= '0;
      regA2_E <= '0;
    end else if (stall) begin
      Tnew_E  <= '0;
      regA3_E <= '0;
      regA1_E <= '0;
      regA2_E <= '0;
    end else begin
      Tnew_E  <= tnewCapture;
      regA3_E <= regA3_D;
      regA1_E <= regA1_D;
      regA2_E <= regA2_D;
    end
  end

  // M and W always drain; a stall only affects what enters E.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      Tnew_M  <= '0;
      regA3_M <= '0;
      regA2_M <= '0;
      Tnew_W  <= '0;
      regA3_W <= '0;
    end else begin
      Tnew_M  <= satDec(Tnew_E);
      regA3_M <= regA3_E;
      regA2_M <= regA2_E;
      Tnew_W  <= satDec(Tnew_M);
      regA3_W <= regA3_M;
    end
  end

  // Stall-cycle counter sticks at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stallCount <= '0;
    end else if (stall && (stallCount != {CNT_W{1'b1}})) begin
      stallCount <= stallCount + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_info_pipe.sv
// tb/tb_hazard_info_pipe.sv - self-checking bench for hazard_info_pipe

module tb_hazard_info_pipe;

  localparam int REG_W  = 5;
  localparam int TNEW_W = 3;
  localparam int CNT_W  = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              stall = 1'b0;
  logic [TNEW_W-1:0] Tnew_D = '0;
  logic [REG_W-1:0]  regA3_D = '0;
  logic [REG_W-1:0]  regA1_D = '0;
  logic [REG_W-1:0]  regA2_D = '0;
  logic [TNEW_W-1:0] Tnew_E, Tnew_M, Tnew_W;
  logic [REG_W-1:0]  regA3_E, regA3_M, regA3_W, regA1_E, regA2_E, regA2_M;
  logic [CNT_W-1:0]  stallCount;

  int checks = 0;
  int errors = 0;

  hazard_info_pipe #(.REG_W(REG_W), .TNEW_W(TNEW_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .stall(stall),
    .Tnew_D(Tnew_D), .regA3_D(regA3_D), .regA1_D(regA1_D), .regA2_D(regA2_D),
    .Tnew_E(Tnew_E), .Tnew_M(Tnew_M), .Tnew_W(Tnew_W),
    .regA3_E(regA3_E), .regA3_M(regA3_M), .regA3_W(regA3_W),
    .regA1_E(regA1_E), .regA2_E(regA2_E), .regA2_M(regA2_M),
    .stallCount(stallCount)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: history of what entered E, newest first. An instruction of age k
  // (k edges after entering E) sits in stage k and has Tnew reduced by k.
  typedef struct {
    int t;
    int a1;
    int a2;
    int a3;
  } rec_t;

  rec_t hist[$];
  int   stalls = 0;

  function automatic rec_t mkRec(input logic s, input int t, input int a3, input int a1, input int a2);
    rec_t r;
    r = '{0, 0, 0, 0};
    if (!s) begin
      r.a1 = a1;
      r.a2 = a2;
      r.a3 = a3;
      r.t  = (a3 == 0) ? 0 : ((t > 2) ? 2 : t);
    end
    return r;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      hist.delete();
      stalls <= 0;
    end else begin
      hist.push_front(mkRec(stall, int'(Tnew_D), int'(regA3_D), int'(regA1_D), int'(regA2_D)));
      if (hist.size() > 3) void'(hist.pop_back());
      if (stall) stalls <= stalls + 1;
    end
  end

  function automatic int expT(input int age);
    int v;
    if (age >= hist.size()) return 0;
    v = hist[age].t - age;
    return (v > 0) ? v : 0;
  endfunction

  function automatic int expA(input int age, input int which);
    if (age >= hist.size()) return 0;
    case (which)
      1: return hist[age].a1;
      2: return hist[age].a2;
      default: return hist[age].a3;
    endcase
  endfunction

  always @(negedge clk) begin
    check("m_Tnew_E", int'(Tnew_E), expT(0));
    check("m_Tnew_M", int'(Tnew_M), expT(1));
    check("m_Tnew_W", int'(Tnew_W), expT(2));
    check("m_regA3_E", int'(regA3_E), expA(0, 3));
    check("m_regA1_E", int'(regA1_E), expA(0, 1));
    check("m_regA2_E", int'(regA2_E), expA(0, 2));
    check("m_regA3_M", int'(regA3_M), expA(1, 3));
    check("m_regA2_M", int'(regA2_M), expA(1, 2));
    check("m_regA3_W", int'(regA3_W), expA(2, 3));
    check("m_stallCount", int'(stallCount), (stalls > CNT_MAX) ? CNT_MAX : stalls);
  end

  // Present D inputs for one edge; returns at the following falling edge.
  task automatic drive(input logic s, input int t, input int a3, input int a1, input int a2);
    stall   = s;
    Tnew_D  = TNEW_W'(t);
    regA3_D = REG_W'(a3);
    regA1_D = REG_W'(a1);
    regA2_D = REG_W'(a2);
    @(negedge clk);
  endtask

  task automatic checkAllZero(input string tag);
    check({tag, "_Tnew_E"}, int'(Tnew_E), 0);
    check({tag, "_Tnew_M"}, int'(Tnew_M), 0);
    check({tag, "_Tnew_W"}, int'(Tnew_W), 0);
    check({tag, "_regA3_E"}, int'(regA3_E), 0);
    check({tag, "_regA3_M"}, int'(regA3_M), 0);
    check({tag, "_regA3_W"}, int'(regA3_W), 0);
    check({tag, "_regA1_E"}, int'(regA1_E), 0);
    check({tag, "_regA2_E"}, int'(regA2_E), 0);
    check({tag, "_regA2_M"}, int'(regA2_M), 0);
    check({tag, "_stallCount"}, int'(stallCount), 0);
  endtask

  initial begin
    @(negedge clk);
    @(negedge clk);
    checkAllZero("rst");
    reset = 1'b1;

    // ALU flow
    drive(0, 1, 8, 9, 10);
    check("alu_Tnew_E", int'(Tnew_E), 1);
    check("alu_regA3_E", int'(regA3_E), 8);
    check("alu_regA1_E", int'(regA1_E), 9);
    check("alu_regA2_E", int'(regA2_E), 10);
    drive(0, 0, 0, 0, 0);
    check("alu_Tnew_M", int'(Tnew_M), 0);
    check("alu_regA3_M", int'(regA3_M), 8);
    check("alu_regA2_M", int'(regA2_M), 10);
    drive(0, 0, 0, 0, 0);
    check("alu_Tnew_W", int'(Tnew_W), 0);
    check("alu_regA3_W", int'(regA3_W), 8);

    // Load-use stall
    drive(0, 2, 5, 0, 0);
    check("ld_Tnew_E", int'(Tnew_E), 2);
    drive(1, 1, 7, 5, 0);
    check("lu_bubble_regA3_E", int'(regA3_E), 0);
    check("lu_bubble_Tnew_E", int'(Tnew_E), 0);
    check("lu_regA3_M", int'(regA3_M), 5);
    check("lu_Tnew_M", int'(Tnew_M), 1);
    check("lu_stallCount", int'(stallCount), 1);
    drive(0, 1, 7, 5, 0);
    check("lu_user_regA3_E", int'(regA3_E), 7);
    check("lu_user_regA1_E", int'(regA1_E), 5);
    check("lu_user_Tnew_E", int'(Tnew_E), 1);
    check("lu_regA3_W", int'(regA3_W), 5);
    check("lu_Tnew_W", int'(Tnew_W), 0);
    check("lu_stallCount2", int'(stallCount), 1);

    // Zero register and clamp
    drive(0, 2, 0, 4, 4);
    check("zr_Tnew_E", int'(Tnew_E), 0);
    check("zr_regA3_E", int'(regA3_E), 0);
    drive(0, 7, 3, 1, 2);
    check("clamp_Tnew_E", int'(Tnew_E), 2);
    check("clamp_regA3_E", int'(regA3_E), 3);

    // Back-to-back stalls behind a load
    drive(0, 2, 6, 1, 1);
    drive(1, 1, 9, 6, 0);
    check("b2b1_regA3_E", int'(regA3_E), 0);
    check("b2b1_regA3_M", int'(regA3_M), 6);
    check("b2b1_Tnew_M", int'(Tnew_M), 1);
    drive(1, 1, 9, 6, 0);
    check("b2b2_regA3_E", int'(regA3_E), 0);
    check("b2b2_regA3_M", int'(regA3_M), 0);
    check("b2b2_regA3_W", int'(regA3_W), 6);
    check("b2b2_Tnew_W", int'(Tnew_W), 0);
    drive(1, 1, 9, 6, 0);
    check("b2b3_regA3_W", int'(regA3_W), 0);
    check("b2b3_stallCount", int'(stallCount), 4);
    drive(0, 1, 9, 6, 0);
    check("b2b_enter_regA3_E", int'(regA3_E), 9);

    // Mid-cycle asynchronous reset
    drive(0, 2, 12, 13, 14);
    stall = 1'b1;
    Tnew_D = 3'd1; regA3_D = 5'd17; regA1_D = 5'd18; regA2_D = 5'd19;
    @(posedge clk);
    #2 reset = 1'b0;
    #1 checkAllZero("arst");
    @(negedge clk);
    reset = 1'b1;
    drive(0, 1, 21, 22, 23);
    check("post_rst_regA3_E", int'(regA3_E), 21);
    check("post_rst_stallCount", int'(stallCount), 0);

    // Saturation: 21 stall cycles, then one more
    for (int i = 0; i < 21; i++) begin
      drive(1, $urandom_range(0, 7), $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31));
    end
    check("sat_stallCount", int'(stallCount), 15);
    drive(1, 0, 0, 0, 0);
    check("sat_hold_stallCount", int'(stallCount), 15);

    // Random mix, checked by the model only
    for (int i = 0; i < 60; i++) begin
      drive(($urandom_range(0, 3) == 0), $urandom_range(0, 7),
            ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(1, 31),
            $urandom_range(0, 31), $urandom_range(0, 31));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_info_pipe.md
# hazard_info_pipe

Carries per-instruction hazard bookkeeping (destination register, source registers, Tnew) from the decode stage down through E, M and W of the five-stage pipeline. It drives the E/M/W-side inputs of the hazard-resolution unit and consumes that unit's `stall` output. On a stall it inserts a bubble into E while older instructions keep draining. It also counts stall cycles for performance inspection.

## Interface
Parameters:
- `REG_W`, 5, register-index width
- `TNEW_W`, 3, Tnew field width
- `CNT_W`, 16, stall-counter width

Ports (name, direction, width, meaning):
- `clk`  in  1  sole clock; all state updates on rising edge
- `reset`  in  1  asynchronous, active-low; low clears all state immediately
- `stall`  in  1  from the hazard-resolution unit; freeze D, bubble into E
- `Tnew_D`  in  TNEW_W  cycles after E entry until the result exists: 0 = none/immediate, 1 = ALU, 2 = load
- `regA3_D`  in  REG_W  destination register of the decoding instruction (0 = no write)
- `regA1_D`, `regA2_D`  in  REG_W  source registers of the decoding instruction
- `Tnew_E`, `Tnew_M`, `Tnew_W`  out  TNEW_W  remaining-latency counts per stage
- `regA3_E`, `regA3_M`, `regA3_W`  out  REG_W  destination register per stage
- `regA1_E`, `regA2_E`  out  REG_W  sources of the instruction in E
- `regA2_M`  out  REG_W  rt of the instruction in M (store-data forwarding)
- `stallCount`  out  CNT_W  saturating count of cycles with `stall` high

## Operation
- State: one E, M and W record each, plus the counter. E holds {Tnew, A1, A2, A3}, M holds {Tnew, A2, A3}, W holds {Tnew, A3}. All outputs come directly from registers.
- Normal edge (`stall`=0):
  - E ← D fields.
  - M ← E with Tnew = sat_dec(Tnew_E).
  - W ← M with Tnew = sat_dec(Tnew_M).
  - sat_dec(x) = x−1 when x>0, else 0.
- Stall edge (`stall`=1):
  - E ← bubble: all fields 0.
  - M and W advance exactly as on a normal edge.
  - D inputs are ignored. The upstream D register is held elsewhere, so the same instruction is presented again next cycle.
- Zero register: if `regA3_D`=0, E captures Tnew=0 regardless of `Tnew_D`. A record with A3=0 never carries a nonzero Tnew into any stage.
- Tnew clamp: `Tnew_D` values above 2 are clamped to 2 on capture.
- Counter: +1 on each edge where `stall`=1; holds at all-ones (no wrap).
- Reset (low, any time including mid-stall): every output is 0 at once and stays 0 while low. The first edge after release behaves as a normal edge.

## Timing
- D→E latency 1 cycle; E→M 1; M→W 1; no combinational input→output path.
- After reset all outputs are 0: Tnew_*=0, regA*_*=0, stallCount=0.
- A load (Tnew_D=2) then shows Tnew_E=2, Tnew_M=1, Tnew_W=0 on successive cycles. An ALU op (1) shows 1, 0, 0.
- Consecutive stalls insert one bubble per cycle. An instruction held in D enters E on the first edge with `stall`=0.
- `stall` is sampled only at the rising edge; glitches between edges have no effect.

## Test plan
- Reset: drive random D inputs, pulse `reset` low mid-cycle → all outputs read 0 before the next edge; stallCount=0.
- ALU flow: D={Tnew=1, A3=8, A1=9, A2=10}, stall=0 → after edge 1: Tnew_E=1, regA3_E=8, regA1_E=9, regA2_E=10; edge 2: Tnew_M=0, regA3_M=8, regA2_M=10; edge 3: Tnew_W=0, regA3_W=8.
- Load-use stall: load {Tnew=2, A3=5} then a user with stall=1 for 1 cycle → E shows A3=0/Tnew=0 bubble while M shows A3=5/Tnew=1; the next edge (stall=0) captures the user into E; stallCount=1.
- Zero register: D={Tnew=2, A3=0} → Tnew_E=0, regA3_E=0; also Tnew_D=7 with A3=3 → Tnew_E=2.
- Saturation: hold stall=1 for 2^CNT_W+5 cycles (use CNT_W=4: 21 cycles) → stallCount=15 and holds.
- Back-to-back stalls: three stall cycles → three bubbles appear sequentially in E, M, W; an M record with Tnew=1 decrements to 0 in W and is never held.
